// File: rtl/uart_tx.sv
// uart_tx: byte-to-serial UART transmitter (start, 8 data LSB-first, optional parity, 1 stop)
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       i_tx_clk,
  input  logic       i_tx_rst,
  input  logic       i_start_bit,
  input  logic [7:0] i_data_in,
  input  logic       i_parity_bit,
  output logic       o_tx_data_out,
  output logic       o_tx_data_done,
  output logic       o_tx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [2:0] state;
  logic [CW-1:0] clk_cnt;
  logic [2:0] bit_idx;
  logic [7:0] data_reg;
  logic par_en;
  always_ff @(posedge i_tx_clk) begin
    if (!i_tx_rst) begin
      state <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      data_reg <= '0;
      par_en <= 1'b0;
      o_tx_data_out <= 1'b1;
      o_tx_data_done <= 1'b0;
      o_tx_busy <= 1'b0;
    end else begin
      o_tx_data_done <= 1'b0;
      if (state == IDLE) begin
        if (i_start_bit) begin
          state <= START;
          data_reg <= i_data_in;
          par_en <= i_parity_bit;
          clk_cnt <= '0;
          bit_idx <= '0;
          o_tx_data_out <= 1'b0;
          o_tx_busy <= 1'b1;
        end
      end else if (clk_cnt != LAST) begin
        clk_cnt <= clk_cnt + CW'(1);
      end else begin
        clk_cnt <= '0;
        case (state)
          START: begin
            state <= DATA;
            o_tx_data_out <= data_reg[0];
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
              state <= par_en ? PARITY : STOP;
              o_tx_data_out <= par_en ? (^data_reg ^ PARITY_ODD) : 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_tx_data_out <= data_reg[bit_idx + 3'd1];
            end
          end
          PARITY: begin
            state <= STOP;
            o_tx_data_out <= 1'b1;
          end
          STOP: begin
            state <= IDLE;
            o_tx_busy <= 1'b0;
            o_tx_data_done <= 1'b1;
          end
          default: begin
            state <= IDLE;
            o_tx_busy <= 1'b0;
            o_tx_data_out <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx with CLKS_PER_BIT=4, even and odd parity instances
module tb_uart_tx;
  localparam int CPB = 4;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, par_in = 1'b0;
  logic [7:0] data = '0;
  logic tx, done, busy, tx_o, done_o, busy_o;
  int total = 0, bad = 0;
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .i_tx_clk(clk), .i_tx_rst(rst), .i_start_bit(start), .i_data_in(data),
    .i_parity_bit(par_in), .o_tx_data_out(tx), .o_tx_data_done(done), .o_tx_busy(busy));
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
    .i_tx_clk(clk), .i_tx_rst(rst), .i_start_bit(start), .i_data_in(data),
    .i_parity_bit(par_in), .o_tx_data_out(tx_o), .o_tx_data_done(done_o), .o_tx_busy(busy_o));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Expects the start edge to have just happened; ep/ep2 are the hand-computed even/odd parity bits.
  task automatic frame(input logic [7:0] d, input logic par, input logic ep, input logic ep2,
                       input int inj, input logic hold);
    logic [10:0] bits, bits2;
    int n;
    n = par ? 11 : 10;
    bits = par ? {1'b1, ep, d, 1'b0} : {2'b11, d, 1'b0};
    bits2 = par ? {1'b1, ep2, d, 1'b0} : {2'b11, d, 1'b0};
    for (int c = 0; c < n * CPB; c++) begin
      chk("line", tx, bits[c / CPB]);
      chk("line_odd", tx_o, bits2[c / CPB]);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      start = hold || (c == inj);
      data = (c == inj) ? 8'hFF : d;
      par_in = (c == inj) ? 1'b0 : par;
      tick;
    end
    chk("done_end", done, 1);
    chk("done_end_odd", done_o, 1);
    chk("busy_end", busy, 0);
    chk("line_end", tx, 1);
  endtask
  task automatic send(input logic [7:0] d, input logic par, input logic ep, input logic ep2,
                      input int inj);
    data = d;
    par_in = par;
    start = 1'b1;
    tick;
    frame(d, par, ep, ep2, inj, 1'b0);
    tick;
    chk("done_pulse_len", done, 0);
    chk("idle_line", tx, 1);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_line", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    tick;
    tick;
    chk("idle_line", tx, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    send(8'hAA, 1'b1, 1'b0, 1'b1, -1);
    send(8'h01, 1'b1, 1'b1, 1'b0, -1);
    send(8'h01, 1'b0, 1'b0, 1'b0, -1);
    send(8'h00, 1'b1, 1'b0, 1'b1, 13);
    for (int i = 0; i < 6; i++) begin
      chk("no_queue_busy", busy, 0);
      chk("no_queue_done", done, 0);
      tick;
    end
    data = 8'h3C;
    par_in = 1'b0;
    start = 1'b1;
    tick;
    frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    tick;
    frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    tick;
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_done_len", done, 0);
    data = 8'h55;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (18) tick;
    chk("pre_abort_busy", busy, 1);
    chk("pre_abort_line", tx, 1'b0);
    rst = 1'b0;
    tick;
    chk("abort_line", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b1;
    for (int i = 0; i < 2 * CPB; i++) begin
      tick;
      chk("abort_no_done", done, 0);
      chk("abort_no_busy", busy, 0);
    end
    send(8'h01, 1'b0, 1'b0, 1'b0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
